// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit: the decoded op, sequencer states and result pair.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4
    } mdu_op_t;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StMul  = 3'd1,
        StDiv  = 3'd2,
        StFix  = 3'd3,
        StDone = 3'd4
    } mdu_state_t;

    localparam int unsigned MDU_DIV_ITERS = 32;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } mdu_result_t;

endpackage

// File: rtl/mdu_div_step.sv
// One combinational restoring-divide iteration on a {rem, quo} shift register.
module mdu_div_step (
    input  logic [63:0] rq_i,
    input  logic [31:0] divisor_i,
    output logic [63:0] rq_o
);

    logic [32:0] rem_sh;
    logic [31:0] diff;

    // Shift in the next dividend bit, then subtract the divisor if it fits.
    always_comb begin
        rem_sh = rq_i[63:31];
        // Remainder after a successful trial is below the divisor, so 32 bits hold it.
        diff   = rem_sh[31:0] - divisor_i;
        if (rem_sh >= {1'b0, divisor_i}) begin
            rq_o = {diff, rq_i[30:0], 1'b1};
        end else begin
            rq_o = {rem_sh[31:0], rq_i[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer for the execute stage.
// Define MDU_DIV0_FAST_EN to finish a divide by zero in one cycle instead of the full iteration.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int unsigned MUL_LAT   = 3,
    parameter int unsigned DIV_ITERS = MDU_DIV_ITERS
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        in_valid_i,
    input  mdu_op_t     op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        flush_i,
    output logic        ok_o,
    output logic        busy_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int unsigned MaxCnt = (MUL_LAT > DIV_ITERS) ? MUL_LAT : DIV_ITERS;
    localparam int unsigned CntW   = $clog2(MaxCnt) + 1;

    mdu_state_t  state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic        signed_q, signed_d;
    logic        sa_q, sa_d;
    logic        sb_q, sb_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [63:0] rq_q, rq_d;
    mdu_result_t res_q, res_d;

    logic [63:0] prod;
    logic [63:0] rq_step;
    logic [31:0] a_abs, b_abs, quo, rem;

    // Sign-extend for MULT, zero-extend for MULTU; the low 64 bits of the product are then exact.
    assign prod = {{32{signed_q & a_q[31]}}, a_q} * {{32{signed_q & b_q[31]}}, b_q};

    mdu_div_step u_div_step (
        .rq_i      (rq_q),
        .divisor_i (b_q),
        .rq_o      (rq_step)
    );

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        signed_d = signed_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        a_d      = a_q;
        b_d      = b_q;
        rq_d     = rq_q;
        res_d    = res_q;
        a_abs    = a_i;
        b_abs    = b_i;
        quo      = rq_q[31:0];
        rem      = rq_q[63:32];

        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    a_d  = a_i;
                    sa_d = a_i[31];
                    sb_d = b_i[31];
                    case (op_i)
                        MDU_MULT, MDU_MULTU: begin
                            signed_d = (op_i == MDU_MULT);
                            b_d      = b_i;
                            cnt_d    = CntW'(MUL_LAT - 1);
                            state_d  = StMul;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            signed_d = (op_i == MDU_DIV);
                            if (op_i == MDU_DIV && a_i[31]) a_abs = -a_i;
                            if (op_i == MDU_DIV && b_i[31]) b_abs = -b_i;
                            b_d     = b_abs;
                            rq_d    = {32'h0, a_abs};
                            cnt_d   = CntW'(DIV_ITERS - 1);
                            state_d = StDiv;
`ifdef MDU_DIV0_FAST_EN
                            if (b_i == 32'h0) begin
                                res_d   = '{hi: a_i, lo: 32'hFFFF_FFFF};
                                state_d = StDone;
                            end
`endif
                        end
                        default: ;
                    endcase
                end
            end
            StMul: begin
                if (cnt_q == '0) begin
                    res_d   = '{hi: prod[63:32], lo: prod[31:0]};
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDiv: begin
                rq_d = rq_step;
                if (cnt_q == '0) begin
                    state_d = StFix;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StFix: begin
                // Divide by zero reports the original dividend untouched by the sign fix.
                if (b_q == 32'h0) begin
                    res_d = '{hi: a_q, lo: 32'hFFFF_FFFF};
                end else begin
                    if (signed_q && (sa_q ^ sb_q)) quo = -rq_q[31:0];
                    if (signed_q && sa_q)          rem = -rq_q[63:32];
                    res_d = '{hi: rem, lo: quo};
                end
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (flush_i) begin
            state_d = StIdle;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            signed_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            rq_q     <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            signed_q <= signed_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rq_q     <= rq_d;
            res_q    <= res_d;
        end
    end

    assign ok_o   = (state_q == StDone) && !flush_i;
    assign busy_o = (state_q != StIdle);
    assign hi_o   = res_q.hi;
    assign lo_o   = res_q.lo;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer against a cycle-count/arithmetic reference model.
module tb_mdu_sequencer;
    import mdu_pkg::*;

    localparam int MulLat   = 3;
    localparam int DivIters = 32;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        in_valid_i = 1'b0;
    mdu_op_t     op_i = MDU_NONE;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        flush_i = 1'b0;
    logic        ok_o, busy_o;
    logic [31:0] hi_o, lo_o;

    int checks = 0;
    int errors = 0;

    // Reference model state: busy flag, cycles left before ok, expected result.
    bit          busy_m = 1'b0;
    int          left_m = 0;
    logic [63:0] exp_res = '0;
    bit          rst_seen = 1'b0;

    mdu_sequencer #(
        .MUL_LAT   (MulLat),
        .DIV_ITERS (DivIters)
    ) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .in_valid_i (in_valid_i),
        .op_i       (op_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .flush_i    (flush_i),
        .ok_o       (ok_o),
        .busy_o     (busy_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h at t=%0t", name, act, req, $time);
        end
    endtask

    // {hi, lo} from plain arithmetic.
    function automatic logic [63:0] model_result(mdu_op_t o, logic [31:0] x, logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            MDU_MULT: begin
                p = 64'(sx * sy);
                return p;
            end
            MDU_MULTU: begin
                p = {32'h0, x} * {32'h0, y};
                return p;
            end
            MDU_DIVU: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            MDU_DIV: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            default: return 64'h0;
        endcase
    endfunction

    // Cycles from acceptance to the ok cycle.
    function automatic int latency(mdu_op_t o, logic [31:0] y);
        if (o == MDU_MULT || o == MDU_MULTU) return MulLat + 1;
`ifdef MDU_DIV0_FAST_EN
        if (y == 0) return 1;
`else
        if (y == 0) return DivIters + 2;
`endif
        return DivIters + 2;
    endfunction

    // Reference model advance on each active edge.
    always @(posedge clk_i) begin
        if (reset_i) begin
            busy_m   = 1'b0;
            left_m   = 0;
            exp_res  = '0;
            rst_seen = 1'b1;
        end else if (flush_i) begin
            busy_m = 1'b0;
        end else if (busy_m) begin
            if (left_m == 0) busy_m = 1'b0;
            else left_m--;
        end else if (in_valid_i && op_i != MDU_NONE) begin
            busy_m  = 1'b1;
            left_m  = latency(op_i, b_i) - 1;
            exp_res = model_result(op_i, a_i, b_i);
        end
    end

    // Compare DUT outputs against the model mid-cycle.
    always @(negedge clk_i) begin
        bit exp_ok;
        if (!reset_i) begin
            exp_ok = busy_m && (left_m == 0) && !flush_i;
            check("ok", 64'(ok_o), 64'(exp_ok));
            check("busy", 64'(busy_o), 64'(busy_m));
            if (exp_ok) check("hi_lo", {hi_o, lo_o}, exp_res);
            if (rst_seen) begin
                check("reset_hi_lo", {hi_o, lo_o}, 64'h0);
                rst_seen = 1'b0;
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (busy_m && t < 200) begin
            @(posedge clk_i);
            #1;
            t++;
        end
    endtask

    task automatic issue(input mdu_op_t o, input logic [31:0] x, input logic [31:0] y);
        wait_idle();
        in_valid_i = 1'b1;
        op_i = o;
        a_i = x;
        b_i = y;
        @(posedge clk_i);
        #1;
        // Operands change while busy; the DUT must ignore them.
        in_valid_i = 1'b0;
        a_i = $urandom;
        b_i = $urandom;
        wait_idle();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        // Pin the model with hand-computed values.
        check("pin_mult", model_result(MDU_MULT, 32'hFFFF_FFFD, 32'd5), 64'hFFFF_FFFF_FFFF_FFF1);
        check("pin_multu", model_result(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF),
              64'hFFFF_FFFE_0000_0001);
        check("pin_div", model_result(MDU_DIV, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        check("pin_divu", model_result(MDU_DIVU, 32'd100, 32'd7), 64'h0000_0002_0000_000E);
        check("pin_div_ovf", model_result(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF),
              64'h0000_0000_8000_0000);
        check("pin_div0", model_result(MDU_DIVU, 32'h1234_5678, 32'h0), 64'h1234_5678_FFFF_FFFF);
        check("pin_lat_mul", 64'(latency(MDU_MULT, 32'd5)), 64'd4);
        check("pin_lat_div", 64'(latency(MDU_DIV, 32'd2)), 64'd34);

        repeat (3) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        @(posedge clk_i);
        #1;

        issue(MDU_MULT, 32'hFFFF_FFFD, 32'd5);
        issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        issue(MDU_DIVU, 32'd100, 32'd7);
        issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(MDU_DIVU, 32'h1234_5678, 32'h0);
        issue(MDU_DIV, 32'hFFFF_FF00, 32'h0);

        // Flush a divide ten cycles after acceptance, then a normal multiply.
        in_valid_i = 1'b1;
        op_i = MDU_DIV;
        a_i = 32'd1000;
        b_i = 32'd3;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        repeat (9) @(posedge clk_i);
        #1;
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        issue(MDU_MULT, 32'h0001_0000, 32'hFFFF_0000);

        // Flush together with a request in IDLE: nothing is accepted.
        in_valid_i = 1'b1;
        flush_i = 1'b1;
        op_i = MDU_MULTU;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        flush_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;

        // Randomized traffic with occasional flush and one mid-stream reset.
        for (int i = 0; i < 4000; i++) begin
            in_valid_i = ($urandom_range(0, 3) != 0);
            op_i = mdu_op_t'(3'($urandom_range(0, 4)));
            a_i = rand_operand();
            b_i = rand_operand();
            flush_i = ($urandom_range(0, 59) == 0);
            reset_i = (i == 2000);
            @(posedge clk_i);
            #1;
        end
        in_valid_i = 1'b0;
        flush_i = 1'b0;
        reset_i = 1'b0;
        wait_idle();
        repeat (2) @(posedge clk_i);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
